regfile_mp: RTL and testbench

Parametrised multi-port general register file for the pipelined MIPS core. It replaces the fixed 2-read/1-write register file and adds:
- configurable width, depth, read-port and write-port counts;
- write-to-read bypass on every read port;
- a per-register in-flight counter (scoreboard) that the decode stage uses for stall decisions;
- a registered write-trace port for the testbench logger.

It sits in the ID stage. Reads are combinational; writes arrive from WB and any extra retire paths.

---
 rtl/regfile_mp.sv | 145 ++++++++++++++
 tb/tb_regfile_mp.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | regfile_mp: multi-port register file with write bypass, per-register       |
// | in-flight scoreboard counters and a registered write-trace port.           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int CNT_W    = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NRD*ADDR_W-1:0]  rd_addr,
  output logic [NRD*DATA_W-1:0]  rd_data,
  output logic [NRD-1:0]         rd_busy,
  input  logic [NWR-1:0]         wr_en,
  input  logic [NWR*ADDR_W-1:0]  wr_addr,
  input  logic [NWR*DATA_W-1:0]  wr_data,
  input  logic [NWR*32-1:0]      wr_pc,
  input  logic                   claim_en,
  input  logic [ADDR_W-1:0]      claim_addr,
  output logic                   claim_ovf,
  output logic [NWR-1:0]         trace_valid,
  output logic [NWR*ADDR_W-1:0]  trace_addr,
  output logic [NWR*DATA_W-1:0]  trace_data,
  output logic [NWR*32-1:0]      trace_pc
);

  localparam int             DEPTH    = 2**ADDR_W;
  localparam int             REL_W    = $clog2(NWR + 1);
  localparam int             EW       = CNT_W + REL_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [CNT_W-1:0]  r_cnt [DEPTH];
  logic              r_ovf;
  logic [DEPTH-1:0]  w_sat;

  logic [NWR-1:0]        r_tv;
  logic [NWR*ADDR_W-1:0] r_ta;
  logic [NWR*DATA_W-1:0] r_td;
  logic [NWR*32-1:0]     r_tp;

  // Number of this cycle's writes that target index a (each releases one claim).
  function automatic logic [REL_W-1:0] f_rel(input logic [ADDR_W-1:0] a);
    logic [REL_W-1:0] n;
    n = '0;
    for (int i = 0; i < NWR; i++)
      if (wr_en[i] && (wr_addr[i*ADDR_W +: ADDR_W] == a)) n = n + REL_W'(1);
    return n;
  endfunction

  generate
    for (genvar r = 0; r < DEPTH; r++) begin : g_reg
      localparam bit IS_Z = (ZERO_REG != 0) && (r == 0);
      logic              w_claim;
      logic [EW-1:0]     w_up;
      logic [EW-1:0]     w_rel;
      logic [EW-1:0]     w_dn;
      logic [CNT_W-1:0]  w_cnt_nxt;
      logic              w_hit;
      logic [DATA_W-1:0] w_val;

      assign w_claim   = claim_en && (claim_addr == ADDR_W'(r));
      assign w_up      = EW'(r_cnt[r]) + EW'(w_claim);
      assign w_rel     = EW'(f_rel(ADDR_W'(r)));
      assign w_dn      = (w_up > w_rel) ? (w_up - w_rel) : '0;
      assign w_sat[r]  = !IS_Z && (w_dn > EW'(CNT_MAX));
      assign w_cnt_nxt = IS_Z ? '0 : (w_sat[r] ? CNT_MAX : w_dn[CNT_W-1:0]);

      // Later write ports overwrite earlier ones, so the highest index wins.
      always_comb begin
        w_hit = 1'b0;
        w_val = '0;
        for (int i = 0; i < NWR; i++) begin
          if (wr_en[i] && (wr_addr[i*ADDR_W +: ADDR_W] == ADDR_W'(r))) begin
            w_hit = 1'b1;
            w_val = wr_data[i*DATA_W +: DATA_W];
          end
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          r_mem[r] <= '0;
          r_cnt[r] <= '0;
        end else begin
          if (w_hit && !IS_Z) r_mem[r] <= w_val;
          r_cnt[r] <= w_cnt_nxt;
        end
      end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [ADDR_W-1:0] w_ra;
      logic [DATA_W-1:0] w_rv;

      assign w_ra = rd_addr[k*ADDR_W +: ADDR_W];

      always_comb begin
        w_rv = r_mem[w_ra];
        for (int i = 0; i < NWR; i++)
          if (wr_en[i] && (wr_addr[i*ADDR_W +: ADDR_W] == w_ra)) w_rv = wr_data[i*DATA_W +: DATA_W];
        if ((ZERO_REG != 0) && (w_ra == '0)) w_rv = '0;
      end

      assign rd_data[k*DATA_W +: DATA_W] = w_rv;
      assign rd_busy[k] = EW'(r_cnt[w_ra]) > EW'(f_rel(w_ra));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) r_ovf <= 1'b0;
    else       r_ovf <= r_ovf | (|w_sat);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tv <= '0;
      r_ta <= '0;
      r_td <= '0;
      r_tp <= '0;
    end else begin
      for (int i = 0; i < NWR; i++) begin
        r_tv[i] <= wr_en[i];
        r_ta[i*ADDR_W +: ADDR_W] <= wr_addr[i*ADDR_W +: ADDR_W];
        r_td[i*DATA_W +: DATA_W] <= ((ZERO_REG != 0) && (wr_addr[i*ADDR_W +: ADDR_W] == '0))
                                    ? '0 : wr_data[i*DATA_W +: DATA_W];
        r_tp[i*32 +: 32] <= wr_pc[i*32 +: 32];
      end
    end
  end

  assign claim_ovf   = r_ovf;
  assign trace_valid = r_tv;
  assign trace_addr  = r_ta;
  assign trace_data  = r_td;
  assign trace_pc    = r_tp;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_regfile_mp: directed and random checks of regfile_mp (NWR=2, NRD=2).    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_regfile_mp;

  localparam int DW = 32, AW = 5, NRD = 2, NWR = 2, CW = 2;
  localparam int MAXC = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [AW-1:0] ra [NRD];
  logic          wen [NWR];
  logic [AW-1:0] wa [NWR];
  logic [DW-1:0] wd [NWR];
  logic [31:0]   wpc [NWR];
  logic          cen;
  logic [AW-1:0] ca;

  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic [NWR-1:0]    wr_en;
  logic [NWR*AW-1:0] wr_addr;
  logic [NWR*DW-1:0] wr_data;
  logic [NWR*32-1:0] wr_pc;
  logic              claim_ovf;
  logic [NWR-1:0]    trace_valid;
  logic [NWR*AW-1:0] trace_addr;
  logic [NWR*DW-1:0] trace_data;
  logic [NWR*32-1:0] trace_pc;

  always_comb begin
    for (int k = 0; k < NRD; k++) rd_addr[k*AW +: AW] = ra[k];
    for (int i = 0; i < NWR; i++) begin
      wr_en[i]             = wen[i];
      wr_addr[i*AW +: AW]  = wa[i];
      wr_data[i*DW +: DW]  = wd[i];
      wr_pc[i*32 +: 32]    = wpc[i];
    end
  end

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NRD), .NWR(NWR), .CNT_W(CW), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_pc(wr_pc),
    .claim_en(cen), .claim_addr(ca), .claim_ovf(claim_ovf),
    .trace_valid(trace_valid), .trace_addr(trace_addr),
    .trace_data(trace_data), .trace_pc(trace_pc)
  );

  // Reference model: architectural register contents, outstanding producers per
  // register, sticky overflow flag, and the trace expected after the last edge.
  logic [DW-1:0]     mem_m [32];
  int                cnt_m [32];
  bit                ovf_m;
  logic [NWR-1:0]    etv;
  logic [NWR*AW-1:0] eta;
  logic [NWR*DW-1:0] etd;
  logic [NWR*32-1:0] etp;
  bit                model_on = 1'b0;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int rel_of(input logic [AW-1:0] a);
    int n = 0;
    for (int i = 0; i < NWR; i++) if (wen[i] && wa[i] == a) n++;
    return n;
  endfunction

  task automatic model_compare();
    logic [DW-1:0] v;
    int c;
    for (int k = 0; k < NRD; k++) begin
      v = mem_m[ra[k]];
      for (int i = 0; i < NWR; i++) if (wen[i] && wa[i] == ra[k]) v = wd[i];
      if (ra[k] == 0) v = '0;
      c = cnt_m[ra[k]] - rel_of(ra[k]);
      chk("rd_data", 128'(rd_data[k*DW +: DW]), 128'(v));
      chk("rd_busy", 128'(rd_busy[k]), 128'(c > 0));
    end
    chk("claim_ovf", 128'(claim_ovf), 128'(ovf_m));
    chk("trace_valid", 128'(trace_valid), 128'(etv));
    chk("trace_addr", 128'(trace_addr), 128'(eta));
    chk("trace_data", 128'(trace_data), 128'(etd));
    chk("trace_pc", 128'(trace_pc), 128'(etp));
  endtask

  task automatic model_update();
    int n;
    if (reset) begin
      for (int r = 0; r < 32; r++) begin mem_m[r] = '0; cnt_m[r] = 0; end
      ovf_m = 1'b0; etv = '0; eta = '0; etd = '0; etp = '0;
      model_on = 1'b1;
    end else begin
      for (int r = 1; r < 32; r++) begin
        n = cnt_m[r] + ((cen && ca == r) ? 1 : 0) - rel_of(AW'(r));
        if (n < 0) n = 0;
        if (n > MAXC) begin n = MAXC; ovf_m = 1'b1; end
        cnt_m[r] = n;
      end
      for (int i = 0; i < NWR; i++) begin
        if (wen[i] && wa[i] != 0) mem_m[wa[i]] = wd[i];
        etv[i] = wen[i];
        eta[i*AW +: AW] = wa[i];
        etd[i*DW +: DW] = (wa[i] == 0) ? '0 : wd[i];
        etp[i*32 +: 32] = wpc[i];
      end
    end
  endtask

  task automatic half();
    @(negedge clk);
    if (model_on) model_compare();
  endtask

  task automatic edge_();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic cyc();
    half();
    edge_();
  endtask

  task automatic idle();
    for (int i = 0; i < NWR; i++) begin wen[i] = 0; wa[i] = '0; wd[i] = '0; wpc[i] = '0; end
    cen = 0; ca = '0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    ra[0] = '0; ra[1] = '0;
    @(posedge clk); model_update(); #1;
    cyc();
    reset = 1'b0;

    // Every register reads 0 after reset.
    for (int r = 0; r < 32; r++) begin
      ra[0] = AW'(r); ra[1] = AW'(31 - r);
      half(); chk("reset_rd0", 128'(rd_data[31:0]), 128'(0)); edge_();
    end

    // Write to $0 is traced but never stored or bypassed.
    wen[0] = 1; wa[0] = 0; wd[0] = 32'hDEADBEEF; wpc[0] = 32'h0040_0000; ra[0] = 0;
    half(); chk("zero_bypass", 128'(rd_data[31:0]), 128'(0)); edge_();
    idle();
    half();
    chk("zero_trace_v", 128'(trace_valid), 128'(2'b01));
    chk("zero_trace_d", 128'(trace_data[31:0]), 128'(0));
    chk("zero_trace_pc", 128'(trace_pc[31:0]), 128'(32'h0040_0000));
    edge_();

    // Same-cycle writes: highest port wins.
    wen[0] = 1; wa[0] = 5; wd[0] = 32'h1111_1111;
    wen[1] = 1; wa[1] = 5; wd[1] = 32'h2222_2222; ra[0] = 5;
    half(); chk("prio_bypass", 128'(rd_data[31:0]), 128'(32'h2222_2222)); edge_();
    idle();
    half();
    chk("prio_store", 128'(rd_data[31:0]), 128'(32'h2222_2222));
    chk("prio_trace_v", 128'(trace_valid), 128'(2'b11));
    edge_();

    // Scoreboard: claim, claim, write, write.
    cen = 1; ca = 8; ra[0] = 8;
    half(); chk("sb_claim_same", 128'(rd_busy[0]), 128'(0)); edge_();
    half(); chk("sb_busy1", 128'(rd_busy[0]), 128'(1)); edge_();
    cen = 0; wen[0] = 1; wa[0] = 8; wd[0] = 32'h8;
    half(); chk("sb_2minus1", 128'(rd_busy[0]), 128'(1)); edge_();
    half(); chk("sb_release", 128'(rd_busy[0]), 128'(0)); edge_();
    idle();

    // Claim + write on $9 with cnt=0 nets to zero.
    cen = 1; ca = 9; wen[0] = 1; wa[0] = 9; ra[0] = 9;
    cyc();
    idle();
    half(); chk("cw_net0", 128'(rd_busy[0]), 128'(0)); edge_();

    // Saturation on $3.
    cen = 1; ca = 3; ra[0] = 3;
    for (int j = 0; j < 4; j++) cyc();
    cen = 0;
    half();
    chk("sat_ovf", 128'(claim_ovf), 128'(1));
    chk("sat_busy", 128'(rd_busy[0]), 128'(1));
    edge_();
    wen[0] = 1; wa[0] = 3;
    cyc(); cyc();
    half(); chk("sat_drain", 128'(rd_busy[0]), 128'(0)); edge_();
    idle();

    // Reset mid-flight.
    cen = 1; ca = 4; cyc();
    ca = 6; cyc();
    cen = 0; wen[0] = 1; wa[0] = 4; wd[0] = 32'h5; cyc();
    idle(); reset = 1'b1; cyc();
    reset = 1'b0; ra[0] = 4; ra[1] = 6;
    half();
    chk("rst_busy4", 128'(rd_busy[0]), 128'(0));
    chk("rst_busy6", 128'(rd_busy[1]), 128'(0));
    chk("rst_rd4", 128'(rd_data[31:0]), 128'(0));
    chk("rst_ovf", 128'(claim_ovf), 128'(0));
    chk("rst_tv", 128'(trace_valid), 128'(0));
    edge_();

    // Random traffic on a narrow address window to provoke collisions.
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < NWR; i++) begin
        wen[i] = ($urandom_range(0, 2) == 0);
        wa[i]  = AW'($urandom_range(0, 7));
        wd[i]  = $urandom;
        wpc[i] = $urandom;
      end
      cen = ($urandom_range(0, 1) == 0);
      ca  = AW'($urandom_range(0, 7));
      for (int k = 0; k < NRD; k++)
        ra[k] = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
